// File: rtl/if_fetch_unit_pkg.sv
// if_fetch_unit_pkg: shared constants, FSM encodings and hold-entry type for the fetch stage
package if_fetch_unit_pkg;
  localparam logic RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic YES = 1'b1;
  localparam logic NO = 1'b0;
  localparam logic STOP = 1'b1;
  localparam logic NO_STOP = 1'b0;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] FETCH = 2'b01;
  localparam logic [1:0] HOLD = 2'b10;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic ds;
  } fetch_ent_t;
endpackage

// File: rtl/if_fetch_unit_if.sv
// if_fetch_unit_if: instruction-memory req/ack bus between fetch (master) and memory (slave)
interface if_fetch_unit_if;
  logic inst_req;
  logic [31:0] inst_addr;
  logic inst_ack;
  logic [31:0] inst_rdata;
  modport master(output inst_req, inst_addr, input inst_ack, inst_rdata);
  modport slave(input inst_req, inst_addr, output inst_ack, inst_rdata);
endinterface

// File: rtl/if_fetch_unit_hold_buf.sv
// if_hold_buf: one-entry skid register holding a fetched {pc, inst, delay-slot} while decode stalls
module if_hold_buf
  import if_fetch_unit_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic unload,
  input  fetch_ent_t d,
  output fetch_ent_t q,
  output logic empty
);
  // capture on load; occupancy tracks load/unload
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
      empty <= 1'b1;
    end else begin
      if (load) q <= d;
      empty <= load ? 1'b0 : unload ? 1'b1 : empty;
    end
  end
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage owning the PC, fetching over req/ack, with delayed-branch redirect (optional IF_FETCH_EXC_EN adds misaligned-fetch exception)
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = if_fetch_unit_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = if_fetch_unit_pkg::NOP_INST
) (
  input  logic clk,
  input  logic rst,
  if_fetch_unit_if.master mem,
  input  logic stall_i,
  input  logic branch_flag_i,
  input  logic [31:0] branch_addr_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic inst_valid_o,
`ifdef IF_FETCH_EXC_EN
  output logic fetch_exc_o,
`endif
  output logic is_delayslot_o
);
  logic [1:0] state, nxt_state;
  logic [31:0] pc_r, redir_tgt, next_pc;
  logic redir_pend, br_now, ack_ok, ds, unload, req, exc, halted;
  fetch_ent_t hb_d, hb_q;
  logic hb_empty;
`ifdef IF_FETCH_EXC_EN
  logic misalign;
  assign misalign = |pc_r[1:0];
  assign req = (state == FETCH) && !misalign;
  assign exc = (state == FETCH) && misalign && !stall_i;
  assign mem.inst_addr = pc_r;
`else
  assign req = (state == FETCH);
  assign exc = 1'b0;
  assign halted = 1'b0;
  assign mem.inst_addr = {pc_r[31:2], 2'b00};
`endif
  assign mem.inst_req = req;
  assign ack_ok = req && mem.inst_ack;
  assign br_now = branch_flag_i && !stall_i;
  assign ds = br_now || redir_pend;
  assign next_pc = ds ? (br_now ? branch_addr_i : redir_tgt) : pc_r + 32'd4;
  assign unload = (state == HOLD) && !stall_i && !hb_empty;
  assign hb_d = {pc_r, mem.inst_rdata, ds};
  if_hold_buf u_hold (
    .clk(clk),
    .rst(rst),
    .load(ack_ok && stall_i),
    .unload(unload),
    .d(hb_d),
    .q(hb_q),
    .empty(hb_empty)
  );
  // next-state selection for the IDLE/FETCH/HOLD sequencer
  always_comb begin
    nxt_state = state == IDLE  ? (halted ? IDLE : FETCH)
              : state == FETCH ? (exc ? IDLE : (ack_ok && stall_i) ? HOLD : FETCH)
              : state == HOLD  ? (unload ? FETCH : HOLD)
              : IDLE;
  end
  // PC, FSM and pending-redirect bookkeeping; a pending redirect is consumed by the next capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc_r <= RESET_PC;
      redir_pend <= 1'b0;
      redir_tgt <= ZeroWord;
    end else begin
      state <= nxt_state;
      pc_r <= ack_ok ? next_pc : pc_r;
      redir_pend <= ack_ok ? 1'b0 : br_now ? 1'b1 : redir_pend;
      redir_tgt <= (!ack_ok && br_now) ? branch_addr_i : redir_tgt;
    end
  end
  // decode-facing registers: frozen under stall, else buffer drain, fresh data, exception or bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_o <= ZeroWord;
      inst_o <= NOP_INST;
      inst_valid_o <= 1'b0;
      is_delayslot_o <= 1'b0;
    end else if (!stall_i) begin
      if (unload) begin
        {pc_o, inst_o, is_delayslot_o} <= hb_q;
        inst_valid_o <= 1'b1;
      end else if (ack_ok) begin
        pc_o <= pc_r;
        inst_o <= mem.inst_rdata;
        inst_valid_o <= 1'b1;
        is_delayslot_o <= ds;
      end else if (exc) begin
        pc_o <= pc_r;
        inst_o <= NOP_INST;
        inst_valid_o <= 1'b1;
        is_delayslot_o <= 1'b0;
      end else begin
        inst_o <= NOP_INST;
        inst_valid_o <= 1'b0;
        is_delayslot_o <= 1'b0;
      end
    end
  end
`ifdef IF_FETCH_EXC_EN
  // exception flag travels with the delivered word; halt is sticky until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_exc_o <= 1'b0;
      halted <= 1'b0;
    end else begin
      if (!stall_i) fetch_exc_o <= exc;
      halted <= halted || exc;
    end
  end
`endif
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: table-driven scoreboard bench for if_fetch_unit (memory returns inst = addr)
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;
  typedef struct {
    logic stall, ack, br;
    logic [31:0] br_addr;
    logic exp_req;
    logic [31:0] exp_addr, exp_pc;
    logic exp_valid, exp_ds;
  } vec_t;
  typedef struct {
    logic [31:0] pc;
    logic valid, ds;
  } exp_t;
  localparam logic [31:0] B = 32'hBFC0_0000;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, br = 1'b0, ack_en = 1'b0;
  logic [31:0] br_addr = 32'h0;
  logic [31:0] pc_o, inst_o;
  logic valid_o, ds_o;
`ifdef IF_FETCH_EXC_EN
  logic exc_o;
`endif
  int applied = 0, errors = 0;
  vec_t vecs[25];
  exp_t sbq[$];
  if_fetch_unit_if mem();
  assign mem.inst_ack = ack_en;
  assign mem.inst_rdata = mem.inst_addr;
  if_fetch_unit dut (
    .clk(clk),
    .rst(rst),
    .mem(mem),
    .stall_i(stall),
    .branch_flag_i(br),
    .branch_addr_i(br_addr),
    .pc_o(pc_o),
    .inst_o(inst_o),
    .inst_valid_o(valid_o),
`ifdef IF_FETCH_EXC_EN
    .fetch_exc_o(exc_o),
`endif
    .is_delayslot_o(ds_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    applied++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, x, $time);
    end
  endtask
  function automatic vec_t mk(input logic s, a, b, input logic [31:0] ba, input logic er,
                              input logic [31:0] ea, ep, input logic ev, ed);
    mk = '{s, a, b, ba, er, ea, ep, ev, ed};
  endfunction
  task automatic run_row(input int i, input vec_t v);
    exp_t e;
    stall = v.stall;
    ack_en = v.ack;
    br = v.br;
    br_addr = v.br_addr;
    #1;
    chk($sformatf("row%0d req", i), {31'b0, mem.inst_req}, {31'b0, v.exp_req});
    if (v.exp_req) chk($sformatf("row%0d addr", i), mem.inst_addr, v.exp_addr);
    sbq.push_back('{v.exp_pc, v.exp_valid, v.exp_ds});
    @(negedge clk);
    e = sbq.pop_front();
    chk($sformatf("row%0d valid", i), {31'b0, valid_o}, {31'b0, e.valid});
    chk($sformatf("row%0d ds", i), {31'b0, ds_o}, {31'b0, e.ds});
    chk($sformatf("row%0d inst", i), inst_o, e.valid ? e.pc : 32'h0);
    if (e.valid) chk($sformatf("row%0d pc", i), pc_o, e.pc);
  endtask
  task automatic chk_reset_outs(input string n);
    chk({n, " pc"}, pc_o, 32'h0);
    chk({n, " inst"}, inst_o, 32'h0);
    chk({n, " valid"}, {31'b0, valid_o}, 32'h0);
    chk({n, " ds"}, {31'b0, ds_o}, 32'h0);
    chk({n, " req"}, {31'b0, mem.inst_req}, 32'h0);
  endtask
  initial begin
    vecs[0]  = mk(0, 1, 0, 0,            0, 0,             0,             0, 0);
    vecs[1]  = mk(0, 1, 0, 0,            1, B,             B,             1, 0);
    vecs[2]  = mk(0, 1, 0, 0,            1, B + 4,         B + 4,         1, 0);
    vecs[3]  = mk(1, 1, 0, 0,            1, B + 8,         B + 4,         1, 0);
    vecs[4]  = mk(1, 0, 0, 0,            0, 0,             B + 4,         1, 0);
    vecs[5]  = mk(1, 0, 0, 0,            0, 0,             B + 4,         1, 0);
    vecs[6]  = mk(0, 0, 0, 0,            0, 0,             B + 8,         1, 0);
    vecs[7]  = mk(0, 1, 0, 0,            1, B + 'hC,       B + 'hC,       1, 0);
    vecs[8]  = mk(0, 1, 1, B + 'h100,    1, B + 'h10,      B + 'h10,      1, 1);
    vecs[9]  = mk(0, 1, 0, 0,            1, B + 'h100,     B + 'h100,     1, 0);
    vecs[10] = mk(0, 0, 1, B + 'h200,    1, B + 'h104,     0,             0, 0);
    vecs[11] = mk(0, 0, 0, 0,            1, B + 'h104,     0,             0, 0);
    vecs[12] = mk(0, 1, 0, 0,            1, B + 'h104,     B + 'h104,     1, 1);
    vecs[13] = mk(0, 1, 0, 0,            1, B + 'h200,     B + 'h200,     1, 0);
    vecs[14] = mk(1, 0, 1, B + 'h300,    1, B + 'h204,     B + 'h200,     1, 0);
    vecs[15] = mk(0, 1, 0, 0,            1, B + 'h204,     B + 'h204,     1, 0);
    vecs[16] = mk(0, 1, 0, 0,            1, B + 'h208,     B + 'h208,     1, 0);
    vecs[17] = mk(0, 1, 1, 32'hFFFF_FFFC, 1, B + 'h20C,    B + 'h20C,     1, 1);
    vecs[18] = mk(0, 1, 0, 0,            1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0);
    vecs[19] = mk(0, 1, 0, 0,            1, 0,             0,             1, 0);
    vecs[20] = mk(0, 0, 0, 0,            1, 4,             0,             0, 0);
    vecs[21] = mk(0, 0, 1, B + 'h400,    1, 4,             0,             0, 0);
    vecs[22] = mk(1, 1, 0, 0,            1, 4,             0,             0, 0);
    vecs[23] = mk(0, 0, 0, 0,            0, 0,             4,             1, 1);
    vecs[24] = mk(0, 1, 0, 0,            1, B + 'h400,     B + 'h400,     1, 0);
    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst = 1'b0;
    for (int i = 0; i < 25; i++) run_row(i, vecs[i]);
    stall = 0;
    ack_en = 0;
    br = 1;
    br_addr = B + 'h500;
    @(negedge clk);
    br = 0;
    rst = 1;
    ack_en = 1;
    @(negedge clk);
    chk_reset_outs("midrst");
    rst = 0;
    #1;
    chk("rel req0", {31'b0, mem.inst_req}, 32'h0);
    @(negedge clk);
    chk("rel valid", {31'b0, valid_o}, 32'h0);
    chk("rel req1", {31'b0, mem.inst_req}, 32'h1);
    chk("rel addr", mem.inst_addr, B);
`ifdef IF_FETCH_EXC_EN
    @(negedge clk);
    br = 1;
    br_addr = B + 'h102;
    @(negedge clk);
    br = 0;
    chk("exc ds pc", pc_o, B + 4);
    chk("exc ds flag", {31'b0, ds_o}, 32'h1);
    chk("exc noreq", {31'b0, mem.inst_req}, 32'h0);
    @(negedge clk);
    chk("exc flag", {31'b0, exc_o}, 32'h1);
    chk("exc pc", pc_o, B + 'h102);
    chk("exc inst", inst_o, 32'h0);
    chk("exc valid", {31'b0, valid_o}, 32'h1);
    repeat (2) @(negedge clk);
    chk("halt req", {31'b0, mem.inst_req}, 32'h0);
    rst = 1;
    @(negedge clk);
    chk("exc clr", {31'b0, exc_o}, 32'h0);
    rst = 0;
`else
    @(negedge clk);
    chk("post pc", pc_o, B);
    chk("post ds", {31'b0, ds_o}, 32'h0);
    chk("post addr", mem.inst_addr, B + 4);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end
endmodule
